modulo_tick_gen: RTL

MODULO_TICK_GEN -- requirements
Module: modulo_tick_gen

---
 rtl/generator_pkg.sv | 16 +
 rtl/mod_cnt_core.sv | 45 ++++
 rtl/modulo_tick_gen.sv | 126 ++++++++++++
 3 files changed

// File: rtl/generator_pkg.sv
`default_nettype none
// ============================================================================
// Module   : generator_pkg
// Purpose  : Shared FSM encoding and default sizing for the modulo tick generator.
// Revision : 1.0
// ============================================================================
package generator_pkg;

    localparam int c_def_width     = 8;
    localparam int c_def_reset_mod = 10;

    localparam logic [0:0] c_st_idle = 1'b0;
    localparam logic [0:0] c_st_run  = 1'b1;

endpackage
`default_nettype wire

// File: rtl/mod_cnt_core.sv
`default_nettype none
// ============================================================================
// Module   : mod_cnt_core
// Purpose  : Modulo-M up counter with terminal-count detect (mod 0 = 2^WIDTH).
// Revision : 1.0
// ============================================================================
module mod_cnt_core
    import generator_pkg::*;
#(
    parameter int WIDTH = c_def_width
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_en,
    input  logic             i_clear,
    input  logic [WIDTH-1:0] i_mod,
    output logic [WIDTH-1:0] o_count,
    output logic             o_wrap
);

    localparam logic [WIDTH-1:0] c_one = WIDTH'(1);

    logic [WIDTH-1:0] r_count;
    logic [WIDTH-1:0] w_last;
    logic             w_wrap;

    // A modulus of 0 underflows to all-ones, giving the full 2^WIDTH period.
    assign w_last = i_mod - c_one;
    assign w_wrap = i_en && (r_count == w_last);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_clear || w_wrap) begin
            r_count <= '0;
        end else if (i_en) begin
            r_count <= r_count + c_one;
        end
    end

    assign o_count = r_count;
    assign o_wrap  = w_wrap;

endmodule
`default_nettype wire

// File: rtl/modulo_tick_gen.sv
`default_nettype none
// ============================================================================
// Module   : modulo_tick_gen
// Purpose  : Programmable modulo tick generator, one-shot or free-running.
// Revision : 1.0
// ============================================================================
module modulo_tick_gen
    import generator_pkg::*;
#(
    parameter int WIDTH     = c_def_width,
    parameter int RESET_MOD = c_def_reset_mod
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_en,
    input  logic             i_start,
    input  logic             i_stop,
    input  logic             i_oneshot,
    input  logic [WIDTH-1:0] i_mod_val,
    input  logic             i_mod_load,
    output logic [WIDTH-1:0] o_count,
    output logic             o_zero,
    output logic             o_busy,
    output logic             o_pend
);

    localparam logic [WIDTH-1:0] c_reset_mod = WIDTH'(RESET_MOD);

    logic [0:0]       r_state;
    logic [0:0]       w_next_state;
    logic             r_oneshot;
    logic             r_zero;
    logic             r_busy;
    logic             r_pend;
    logic [WIDTH-1:0] r_mod;
    logic [WIDTH-1:0] r_shadow;

    logic             w_core_en;
    logic             w_core_clear;
    logic             w_arm;
    logic             w_wrap;
    logic [WIDTH-1:0] w_count;

    mod_cnt_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_en    (w_core_en),
        .i_clear (w_core_clear),
        .i_mod   (r_mod),
        .o_count (w_count),
        .o_wrap  (w_wrap)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= c_st_idle;
            r_busy    <= 1'b0;
            r_zero    <= 1'b0;
            r_oneshot <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_busy  <= (w_next_state == c_st_run);
            r_zero  <= w_wrap;
            if (w_arm) begin
                r_oneshot <= i_oneshot;
            end
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_st_idle: begin
                if (i_start && !i_stop) begin
                    w_next_state = c_st_run;
                end
            end
            c_st_run: begin
                if (i_stop || (w_wrap && r_oneshot)) begin
                    w_next_state = c_st_idle;
                end
            end
            default: w_next_state = c_st_idle;
        endcase
    end

    // Stop outranks both counting and start, so it gates the counter enable.
    always_comb begin
        w_core_en    = (r_state == c_st_run) && i_en && !i_stop;
        w_core_clear = (r_state == c_st_idle) || i_stop;
        w_arm        = (r_state == c_st_idle) && i_start && !i_stop;
    end

    // The shadow only moves into the active modulus at a period boundary or on stop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mod    <= c_reset_mod;
            r_shadow <= c_reset_mod;
            r_pend   <= 1'b0;
        end else if (r_state == c_st_idle) begin
            if (i_mod_load) begin
                r_mod <= i_mod_val;
            end
        end else if (i_stop || w_wrap) begin
            if (i_mod_load) begin
                r_mod  <= i_mod_val;
                r_pend <= 1'b0;
            end else if (r_pend) begin
                r_mod  <= r_shadow;
                r_pend <= 1'b0;
            end
        end else if (i_mod_load) begin
            r_shadow <= i_mod_val;
            r_pend   <= 1'b1;
        end
    end

    assign o_count = w_count;
    assign o_zero  = r_zero;
    assign o_busy  = r_busy;
    assign o_pend  = r_pend;

endmodule
`default_nettype wire
